// File: rtl/msrh_lsu_pkg.sv
// =============================================================================
// msrh_lsu_pkg : shared LSU types for the L1D load refill queue
// Revision     : 1.0
// =============================================================================
`default_nettype none

package msrh_lsu_pkg;

    localparam int LRQ_SIZE   = 4;
    localparam int PADDR_W    = 56;
    localparam int LINE_W     = 512;
    localparam int LINE_OFS_W = 6;
    localparam int LRQ_TAG_W  = $clog2(LRQ_SIZE);

    typedef enum logic [1:0] {
        LRQ_IDLE  = 2'd0,
        LRQ_REQ   = 2'd1,
        LRQ_WAIT  = 2'd2,
        LRQ_WRITE = 2'd3
    } lrq_state_t;

    typedef struct packed {
        lrq_state_t           state;
        logic [PADDR_W-1:0]   paddr;
        logic [LINE_W-1:0]    data;
    } lrq_entry_t;

    typedef struct packed {
        logic [PADDR_W-1:0]   paddr;
        logic [LRQ_TAG_W-1:0] tag;
    } l2_req_t;

    typedef struct packed {
        logic [LRQ_TAG_W-1:0] tag;
        logic [LINE_W-1:0]    data;
    } l2_resp_t;

    // Isolates the lowest set bit; callers size the vector to their entry count.
    function automatic logic [31:0] bit_oh_lowest(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/msrh_l1d_lrq_entry.sv
// =============================================================================
// msrh_l1d_lrq_entry : one refill slot (state machine, line address, line data)
// Revision           : 1.0
// =============================================================================
`default_nettype none

module msrh_l1d_lrq_entry
    import msrh_lsu_pkg::*;
#(
    parameter int PADDR_W = msrh_lsu_pkg::PADDR_W,
    parameter int LINE_W  = msrh_lsu_pkg::LINE_W
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_alloc,
    input  logic [PADDR_W-1:0] i_alloc_paddr,
    input  logic               i_l2_req_fire,
    input  logic               i_l2_resp_valid,
    input  logic [LINE_W-1:0]  i_l2_resp_data,
    input  logic               i_l1d_wr_fire,
    output logic [1:0]         o_state,
    output logic [PADDR_W-1:0] o_paddr,
    output logic [LINE_W-1:0]  o_data
);

    lrq_state_t         state_q;
    lrq_state_t         state_d;
    logic [PADDR_W-1:0] paddr_q;
    logic [LINE_W-1:0]  data_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= LRQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LRQ_IDLE:  if (i_alloc)         state_d = LRQ_REQ;
            LRQ_REQ:   if (i_l2_req_fire)   state_d = LRQ_WAIT;
            LRQ_WAIT:  if (i_l2_resp_valid) state_d = LRQ_WRITE;
            LRQ_WRITE: if (i_l1d_wr_fire)   state_d = LRQ_IDLE;
            default:                        state_d = LRQ_IDLE;
        endcase
    end

    always_comb begin
        o_state = state_q;
        o_paddr = paddr_q;
        o_data  = data_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            paddr_q <= '0;
        end else if (state_q == LRQ_IDLE && i_alloc) begin
            paddr_q <= i_alloc_paddr;
        end
    end

    // Data is only meaningful in WRITE, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (state_q == LRQ_WAIT && i_l2_resp_valid) begin
            data_q <= i_l2_resp_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/msrh_l1d_lrq.sv
// =============================================================================
// msrh_l1d_lrq : L1D load refill queue - miss merge, L2 refill, L1D fill, resolve
// Revision     : 1.0
// =============================================================================
`default_nettype none

module msrh_l1d_lrq
    import msrh_lsu_pkg::*;
#(
    parameter int LRQ_SIZE   = msrh_lsu_pkg::LRQ_SIZE,
    parameter int PADDR_W    = msrh_lsu_pkg::PADDR_W,
    parameter int LINE_W     = msrh_lsu_pkg::LINE_W,
    parameter int LINE_OFS_W = msrh_lsu_pkg::LINE_OFS_W,
    localparam int TAG_W     = $clog2(LRQ_SIZE)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_load,
    input  logic [PADDR_W-1:0]  i_req_paddr,
    output logic                o_resp_conflict,
    output logic                o_resp_full,
    output logic [LRQ_SIZE-1:0] o_resp_lrq_index_oh,
    output logic                o_l2_req_valid,
    input  logic                i_l2_req_ready,
    output logic [PADDR_W-1:0]  o_l2_req_paddr,
    output logic [TAG_W-1:0]    o_l2_req_tag,
    input  logic                i_l2_resp_valid,
    input  logic [TAG_W-1:0]    i_l2_resp_tag,
    input  logic [LINE_W-1:0]   i_l2_resp_data,
    output logic                o_l1d_wr_valid,
    input  logic                i_l1d_wr_ready,
    output logic [PADDR_W-1:0]  o_l1d_wr_paddr,
    output logic [LINE_W-1:0]   o_l1d_wr_data,
    output logic                o_lrq_resolve_valid,
    output logic [LRQ_SIZE-1:0] o_lrq_resolve_index_oh
);

    logic [1:0]          w_state [LRQ_SIZE];
    logic [PADDR_W-1:0]  w_paddr [LRQ_SIZE];
    logic [LINE_W-1:0]   w_data  [LRQ_SIZE];
    logic [LRQ_SIZE-1:0] w_busy, w_match, w_req, w_wait, w_write, w_resp_hit;
    logic [LRQ_SIZE-1:0] w_free_oh, w_alloc_oh, w_l2_sel, w_wr_sel, w_l2_fire_oh, w_wr_fire_oh;
    logic [PADDR_W-1:0]  w_req_line;
    logic                w_hit;

    logic                l2_lock_q, wr_lock_q, resolve_valid_q;
    logic [LRQ_SIZE-1:0] l2_sel_q, wr_sel_q, resolve_oh_q;

    assign w_req_line = {i_req_paddr[PADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};

    for (genvar gi = 0; gi < LRQ_SIZE; gi++) begin : g_entry
        msrh_l1d_lrq_entry #(
            .PADDR_W (PADDR_W),
            .LINE_W  (LINE_W)
        ) u_entry (
            .i_clk           (i_clk),
            .i_reset_n       (i_reset_n),
            .i_alloc         (w_alloc_oh[gi]),
            .i_alloc_paddr   (w_req_line),
            .i_l2_req_fire   (w_l2_fire_oh[gi]),
            .i_l2_resp_valid (w_resp_hit[gi]),
            .i_l2_resp_data  (i_l2_resp_data),
            .i_l1d_wr_fire   (w_wr_fire_oh[gi]),
            .o_state         (w_state[gi]),
            .o_paddr         (w_paddr[gi]),
            .o_data          (w_data[gi])
        );

        assign w_busy[gi]     = (w_state[gi] != LRQ_IDLE);
        assign w_req[gi]      = (w_state[gi] == LRQ_REQ);
        assign w_wait[gi]     = (w_state[gi] == LRQ_WAIT);
        assign w_write[gi]    = (w_state[gi] == LRQ_WRITE);
        assign w_match[gi]    = w_busy[gi] && (w_paddr[gi] == w_req_line);
        assign w_resp_hit[gi] = i_l2_resp_valid && (i_l2_resp_tag == TAG_W'(gi));
    end

    // Lookup uses registered state only, so a slot draining this cycle still matches.
    assign w_hit      = |w_match;
    assign w_free_oh  = LRQ_SIZE'(bit_oh_lowest(32'(~w_busy)));
    assign w_alloc_oh = (i_load && !w_hit) ? w_free_oh : '0;

    assign o_resp_conflict     = i_load && w_hit;
    assign o_resp_full         = i_load && !w_hit && !(|w_free_oh);
    assign o_resp_lrq_index_oh = !i_load ? '0 : (w_hit ? w_match : w_free_oh);

    // A stalled request stays locked on its slot so a newly-filled lower slot cannot displace it.
    assign w_l2_sel       = l2_lock_q ? l2_sel_q : LRQ_SIZE'(bit_oh_lowest(32'(w_req)));
    assign w_wr_sel       = wr_lock_q ? wr_sel_q : LRQ_SIZE'(bit_oh_lowest(32'(w_write)));
    assign o_l2_req_valid = |w_l2_sel;
    assign o_l1d_wr_valid = |w_wr_sel;
    assign w_l2_fire_oh   = i_l2_req_ready ? w_l2_sel : '0;
    assign w_wr_fire_oh   = i_l1d_wr_ready ? w_wr_sel : '0;

    always_comb begin
        o_l2_req_paddr = '0;
        o_l2_req_tag   = '0;
        o_l1d_wr_paddr = '0;
        o_l1d_wr_data  = '0;
        for (int i = 0; i < LRQ_SIZE; i++) begin
            if (w_l2_sel[i]) begin
                o_l2_req_paddr = o_l2_req_paddr | w_paddr[i];
                o_l2_req_tag   = o_l2_req_tag | TAG_W'(i);
            end
            if (w_wr_sel[i]) begin
                o_l1d_wr_paddr = o_l1d_wr_paddr | w_paddr[i];
                o_l1d_wr_data  = o_l1d_wr_data | w_data[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            l2_lock_q       <= 1'b0;
            l2_sel_q        <= '0;
            wr_lock_q       <= 1'b0;
            wr_sel_q        <= '0;
            resolve_valid_q <= 1'b0;
            resolve_oh_q    <= '0;
        end else begin
            l2_lock_q       <= o_l2_req_valid && !i_l2_req_ready;
            l2_sel_q        <= w_l2_sel;
            wr_lock_q       <= o_l1d_wr_valid && !i_l1d_wr_ready;
            wr_sel_q        <= w_wr_sel;
            resolve_valid_q <= |w_wr_fire_oh;
            resolve_oh_q    <= w_wr_fire_oh;
        end
    end

    assign o_lrq_resolve_valid    = resolve_valid_q;
    assign o_lrq_resolve_index_oh = resolve_oh_q;

    always_ff @(posedge i_clk) begin
        if (i_reset_n && i_l2_resp_valid) begin
            assert (!(|(w_resp_hit & w_l2_fire_oh)))
                else $error("lrq: L2 response in same cycle as its request handshake");
            assert (|(w_resp_hit & w_wait))
                else $warning("lrq: L2 response for a slot not awaiting data was ignored");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_msrh_l1d_lrq.sv
// =============================================================================
// tb_msrh_l1d_lrq : directed vectors plus randomized traffic against a slot model
// Revision        : 1.0
// =============================================================================
`default_nettype none

module tb_msrh_l1d_lrq;

    localparam int N  = 4;
    localparam int PW = 56;
    localparam int LW = 512;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [PW-1:0] req_paddr;
    logic          resp_conflict, resp_full;
    logic [N-1:0]  resp_oh;
    logic          l2_valid, l2_ready;
    logic [PW-1:0] l2_paddr;
    logic [TW-1:0] l2_tag;
    logic          l2r_valid;
    logic [TW-1:0] l2r_tag;
    logic [LW-1:0] l2r_data;
    logic          wr_valid, wr_ready;
    logic [PW-1:0] wr_paddr;
    logic [LW-1:0] wr_data;
    logic          res_valid;
    logic [N-1:0]  res_oh;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    msrh_l1d_lrq u_dut (
        .i_clk                  (clk),
        .i_reset_n              (rst_n),
        .i_load                 (load),
        .i_req_paddr            (req_paddr),
        .o_resp_conflict        (resp_conflict),
        .o_resp_full            (resp_full),
        .o_resp_lrq_index_oh    (resp_oh),
        .o_l2_req_valid         (l2_valid),
        .i_l2_req_ready         (l2_ready),
        .o_l2_req_paddr         (l2_paddr),
        .o_l2_req_tag           (l2_tag),
        .i_l2_resp_valid        (l2r_valid),
        .i_l2_resp_tag          (l2r_tag),
        .i_l2_resp_data         (l2r_data),
        .o_l1d_wr_valid         (wr_valid),
        .i_l1d_wr_ready         (wr_ready),
        .o_l1d_wr_paddr         (wr_paddr),
        .o_l1d_wr_data          (wr_data),
        .o_lrq_resolve_valid    (res_valid),
        .o_lrq_resolve_index_oh (res_oh)
    );

    typedef struct {
        logic [PW-1:0] paddr;
        logic          conflict;
        logic          full;
        logic [N-1:0]  oh;
    } vec_t;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load      = 1'b0;
        req_paddr = '0;
        l2_ready  = 1'b0;
        wr_ready  = 1'b0;
        l2r_valid = 1'b0;
        l2r_tag   = '0;
        l2r_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Slot model: phase 0 free, 1 needs L2 request, 2 awaiting data, 3 needs L1D write
    int            m_ph [N];
    logic [PW-1:0] m_ln [N];
    logic [LW-1:0] m_dt [N];
    int            m_l2_hold, m_wr_hold;
    logic [N-1:0]  m_res;

    initial begin
        vec_t          tv [7];
        logic [LW-1:0] pat_a5, d0, d1;
        int            fires;

        tv[0] = '{56'h8000_1048, 1'b0, 1'b0, 4'b0001};
        tv[1] = '{56'h8000_1070, 1'b1, 1'b0, 4'b0001};
        tv[2] = '{56'h8000_2000, 1'b0, 1'b0, 4'b0010};
        tv[3] = '{56'h8000_3008, 1'b0, 1'b0, 4'b0100};
        tv[4] = '{56'h8000_4000, 1'b0, 1'b0, 4'b1000};
        tv[5] = '{56'h8000_5000, 1'b0, 1'b1, 4'b0000};
        tv[6] = '{56'h8000_303F, 1'b1, 1'b0, 4'b0100};
        pat_a5 = {64{8'hA5}};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_conflict", resp_conflict, 0);
        chk("rst_full", resp_full, 0);
        chk("rst_oh", resp_oh, 0);
        chk("rst_l2_valid", l2_valid, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_oh", res_oh, 0);

        // ---------------- single miss with backpressure ----------------
        load = 1'b1; req_paddr = 56'h8000_1048;
        #1;
        chk("single_oh", resp_oh, 4'b0001);
        chk("single_conflict", resp_conflict, 0);
        chk("single_full", resp_full, 0);
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("l2_bp_valid", l2_valid, 1);
            chk("l2_bp_paddr", l2_paddr, 56'h8000_1040);
            chk("l2_bp_tag", l2_tag, 0);
            tick();
        end
        l2_ready = 1'b1;
        #1;
        chk("l2_fire_valid", l2_valid, 1);
        tick();
        l2_ready = 1'b0;
        #1;
        chk("l2_once", l2_valid, 0);
        l2r_valid = 1'b1; l2r_tag = 0; l2r_data = pat_a5;
        tick();
        l2r_valid = 1'b0; l2r_data = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wr_bp_valid", wr_valid, 1);
            chk("wr_bp_paddr", wr_paddr, 56'h8000_1040);
            chk("wr_bp_data", wr_data, pat_a5);
            chk("wr_bp_res", res_valid, 0);
            tick();
        end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        #1;
        chk("single_res_valid", res_valid, 1);
        chk("single_res_oh", res_oh, 4'b0001);
        chk("single_wr_done", wr_valid, 0);
        tick();
        chk("single_res_clear", res_oh, 0);

        // ---------------- merge / full table ----------------
        do_reset();
        for (int v = 0; v < 7; v++) begin
            load = 1'b1; req_paddr = tv[v].paddr;
            #1;
            chk($sformatf("tv%0d_conflict", v), resp_conflict, tv[v].conflict);
            chk($sformatf("tv%0d_full", v), resp_full, tv[v].full);
            chk($sformatf("tv%0d_oh", v), resp_oh, tv[v].oh);
            tick();
        end
        load = 1'b0;
        #1;
        chk("tbl_l2_paddr", l2_paddr, 56'h8000_1040);
        chk("tbl_l2_tag", l2_tag, 0);
        l2_ready = 1'b1;
        fires = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (l2_valid) fires++;
            tick();
        end
        l2_ready = 1'b0;
        chk("tbl_l2_fires", fires, 4);

        // ---------------- reset while slots await data ----------------
        rst_n = 1'b0;
        #1;
        chk("rst_mid_l2", l2_valid, 0);
        chk("rst_mid_wr", wr_valid, 0);
        chk("rst_mid_res", res_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        l2r_valid = 1'b1; l2r_tag = 0; l2r_data = pat_a5;
        tick();
        l2r_valid = 1'b0;
        #1;
        chk("late_resp_no_wr", wr_valid, 0);
        load = 1'b1; req_paddr = 56'h8000_7000;
        #1;
        chk("post_rst_oh", resp_oh, 4'b0001);
        tick();
        load = 1'b0;

        // ---------------- out-of-order responses ----------------
        do_reset();
        d0 = {16{32'h0000_AAAA}};
        d1 = {16{32'h1111_BBBB}};
        l2_ready = 1'b1; wr_ready = 1'b1;
        load = 1'b1; req_paddr = 56'h8001_0000;
        tick();
        req_paddr = 56'h8002_0000;
        tick();
        load = 1'b0;
        tick();
        tick();
        l2r_valid = 1'b1; l2r_tag = 1; l2r_data = d1;
        tick();
        l2r_tag = 0; l2r_data = d0;
        #1;
        chk("ooo_wr1_paddr", wr_paddr, 56'h8002_0000);
        chk("ooo_wr1_data", wr_data, d1);
        tick();
        l2r_valid = 1'b0;
        load = 1'b1; req_paddr = 56'h8003_0000;
        #1;
        chk("ooo_wr0_paddr", wr_paddr, 56'h8001_0000);
        chk("ooo_wr0_data", wr_data, d0);
        chk("ooo_res1", res_oh, 4'b0010);
        chk("ooo_realloc1", resp_oh, 4'b0010);
        tick();
        load = 1'b0;
        #1;
        chk("ooo_res0", res_oh, 4'b0001);

        // ---------------- randomized traffic against the slot model ----------------
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_ph[i] = 0; m_ln[i] = '0; m_dt[i] = '0;
        end
        m_l2_hold = -1; m_wr_hold = -1; m_res = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int            waiting [$];
            int            mt, fr, ls, ws;
            logic [PW-1:0] line;
            logic [N-1:0]  exp_oh;

            load      = 1'($urandom_range(0, 1));
            req_paddr = PW'(32'h8000_0000 + ($urandom_range(0, 7) << 6) + $urandom_range(0, 63));
            l2_ready  = 1'($urandom_range(0, 1));
            wr_ready  = 1'($urandom_range(0, 1));
            for (int j = 0; j < LW / 32; j++) l2r_data[j*32 +: 32] = $urandom;
            waiting.delete();
            for (int i = 0; i < N; i++) if (m_ph[i] == 2) waiting.push_back(i);
            if (waiting.size() > 0 && $urandom_range(0, 2) != 0) begin
                l2r_valid = 1'b1;
                l2r_tag   = TW'(waiting[$urandom_range(0, waiting.size() - 1)]);
            end else begin
                l2r_valid = 1'b0;
                l2r_tag   = TW'($urandom_range(0, N - 1));
            end
            #1;

            line = req_paddr & ~PW'(63);
            mt = -1; fr = -1; ls = -1; ws = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (m_ph[i] != 0 && m_ln[i] == line) mt = i;
                if (m_ph[i] == 0) fr = i;
                if (m_ph[i] == 1) ls = i;
                if (m_ph[i] == 3) ws = i;
            end
            if (m_l2_hold >= 0) ls = m_l2_hold;
            if (m_wr_hold >= 0) ws = m_wr_hold;
            exp_oh = '0;
            if (load && mt >= 0) exp_oh[mt] = 1'b1;
            else if (load && fr >= 0) exp_oh[fr] = 1'b1;

            chk("rnd_conflict", resp_conflict, load && mt >= 0);
            chk("rnd_full", resp_full, load && mt < 0 && fr < 0);
            chk("rnd_oh", resp_oh, exp_oh);
            chk("rnd_l2_valid", l2_valid, ls >= 0);
            if (ls >= 0) begin
                chk("rnd_l2_paddr", l2_paddr, m_ln[ls]);
                chk("rnd_l2_tag", l2_tag, ls);
            end
            chk("rnd_wr_valid", wr_valid, ws >= 0);
            if (ws >= 0) begin
                chk("rnd_wr_paddr", wr_paddr, m_ln[ws]);
                chk("rnd_wr_data", wr_data, m_dt[ws]);
            end
            chk("rnd_res_valid", res_valid, |m_res);
            chk("rnd_res_oh", res_oh, m_res);

            m_res = '0;
            if (ws >= 0 && wr_ready) begin
                m_ph[ws] = 0; m_res[ws] = 1'b1; m_wr_hold = -1;
            end else begin
                m_wr_hold = ws;
            end
            if (l2r_valid && m_ph[l2r_tag] == 2) begin
                m_ph[l2r_tag] = 3; m_dt[l2r_tag] = l2r_data;
            end
            if (ls >= 0 && l2_ready) begin
                m_ph[ls] = 2; m_l2_hold = -1;
            end else begin
                m_l2_hold = ls;
            end
            if (load && mt < 0 && fr >= 0) begin
                m_ph[fr] = 1; m_ln[fr] = line;
            end
            tick();
        end

        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
